indirect_target_buffer: RTL and testbench

//  Direct-mapped target predictor for JALR (cf JumpR) sitting directly downstream of the branch unit.

---
 rtl/indirect_target_buffer_pkg.sv | 36 +++
 rtl/indirect_target_buffer_itb_array.sv | 29 ++
 rtl/indirect_target_buffer.sv | 139 +++++++++++++
 tb/tb_indirect_target_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/indirect_target_buffer_pkg.sv
// Shared types for the indirect (JALR) target buffer: branch-resolve bus, entry layout, FSM states.
package indirect_target_buffer_pkg;

    localparam int unsigned VLEN           = 39;
    localparam int unsigned ITB_NR_ENTRIES = 64;
    localparam int unsigned ITB_IDX_BITS   = $clog2(ITB_NR_ENTRIES);
    localparam int unsigned ITB_TAG_BITS   = VLEN - ITB_IDX_BITS - 1;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        cf_t             cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic                    valid;
        logic [ITB_TAG_BITS-1:0] tag;
        logic [VLEN-1:0]         target;
    } itb_entry_t;

    typedef enum logic {
        ITB_IDLE  = 1'b0,
        ITB_SWEEP = 1'b1
    } itb_state_e;

endpackage

// File: rtl/indirect_target_buffer_itb_array.sv
// Entry storage modelled as an SRAM: one synchronous read port, one write port, read-before-write, no reset.
module itb_array
    import indirect_target_buffer_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = ITB_NR_ENTRIES,
    parameter type         entry_t    = itb_entry_t
) (
    input  logic                          clk_i,
    input  logic                          re_i,
    input  logic [$clog2(NR_ENTRIES)-1:0] raddr_i,
    output entry_t                        rdata_o,
    input  logic                          we_i,
    input  logic [$clog2(NR_ENTRIES)-1:0] waddr_i,
    input  entry_t                        wdata_i
);

    entry_t mem [NR_ENTRIES];

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/indirect_target_buffer.sv
// Direct-mapped JALR target predictor: installs mispredicted register-jump targets, serves
// registered lookups, and invalidates every entry through a one-entry-per-cycle sweep.
module indirect_target_buffer
    import indirect_target_buffer_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = ITB_NR_ENTRIES
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  bp_resolve_t     resolved_branch_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            lookup_hit_o,
    output logic [VLEN-1:0] lookup_target_o,
    output logic            flush_busy_o
);

    localparam int unsigned IDX_BITS = $clog2(NR_ENTRIES);
    localparam int unsigned TAG_BITS = VLEN - IDX_BITS - 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [VLEN-1:0]     target;
    } entry_t;

    itb_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] cnt_q;
    logic                sweep_c;
    logic                install_c;
    logic                we_c;
    logic [IDX_BITS-1:0] waddr_c;
    entry_t              wdata_c;
    entry_t              rdata;
    logic                req_q;
    logic [TAG_BITS-1:0] tag_q;
    logic                unused_pc_lsb;

    assign unused_pc_lsb = resolved_branch_i.pc[0] ^ lookup_pc_i[0];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ITB_SWEEP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush always (re)starts the sweep
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ITB_IDLE: begin
                if (flush_i) begin
                    state_d = ITB_SWEEP;
                end
            end
            ITB_SWEEP: begin
                if (!flush_i && cnt_q == IDX_BITS'(NR_ENTRIES - 1)) begin
                    state_d = ITB_IDLE;
                end
            end
            default: state_d = ITB_SWEEP;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        sweep_c      = 1'b0;
        flush_busy_o = 1'b0;
        if (state_q == ITB_SWEEP) begin
            sweep_c      = 1'b1;
            flush_busy_o = 1'b1;
        end
    end

    // Sweep counter wraps to zero on the final sweep cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cnt_q <= '0;
        end else if (state_q == ITB_SWEEP) begin
            cnt_q <= cnt_q + IDX_BITS'(1);
        end
    end

    assign install_c = resolved_branch_i.valid
                     & resolved_branch_i.is_mispredict
                     & (resolved_branch_i.cf_type == JumpR)
                     & ~debug_mode_i
                     & ~resolved_branch_i.target_address[0]
                     & (state_q == ITB_IDLE)
                     & ~flush_i;

    // Single write port shared by sweep and install; state makes them exclusive
    always_comb begin
        we_c    = sweep_c | install_c;
        waddr_c = resolved_branch_i.pc[IDX_BITS:1];
        wdata_c = '{valid:  1'b1,
                    tag:    resolved_branch_i.pc[VLEN-1:IDX_BITS+1],
                    target: resolved_branch_i.target_address};
        if (sweep_c) begin
            waddr_c = cnt_q;
            wdata_c = '0;
        end
    end

    itb_array #(
        .NR_ENTRIES (NR_ENTRIES),
        .entry_t    (entry_t)
    ) i_itb_array (
        .clk_i   (clk_i),
        .re_i    (lookup_valid_i),
        .raddr_i (lookup_pc_i[IDX_BITS:1]),
        .rdata_o (rdata),
        .we_i    (we_c),
        .waddr_i (waddr_c),
        .wdata_i (wdata_c)
    );

    // Request qualifier and tag travel alongside the synchronous array read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q <= 1'b0;
            tag_q <= '0;
        end else begin
            req_q <= lookup_valid_i & (state_q == ITB_IDLE);
            tag_q <= lookup_pc_i[VLEN-1:IDX_BITS+1];
        end
    end

    always_comb begin
        lookup_hit_o    = req_q & rdata.valid & (rdata.tag == tag_q);
        lookup_target_o = lookup_hit_o ? rdata.target : '0;
    end

endmodule

// File: tb/tb_indirect_target_buffer.sv
// Randomised scoreboard bench for indirect_target_buffer against a whole-PC reference model.
module tb_indirect_target_buffer;
    import indirect_target_buffer_pkg::*;

    localparam int unsigned N = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            dbg;
    bp_resolve_t     rb;
    logic            lv;
    logic [VLEN-1:0] lpc;
    logic            hit;
    logic [VLEN-1:0] tgt;
    logic            busy;

    int n_vec  = 0;
    int n_miss = 0;

    indirect_target_buffer #(.NR_ENTRIES(N)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .debug_mode_i      (dbg),
        .resolved_branch_i (rb),
        .lookup_valid_i    (lv),
        .lookup_pc_i       (lpc),
        .lookup_hit_o      (hit),
        .lookup_target_o   (tgt),
        .flush_busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: whole PCs per slot; a flush empties everything at once and
    // simply hides the table for 64 cycles.
    logic            m_v   [N];
    logic [VLEN-1:0] m_pc  [N];
    logic [VLEN-1:0] m_tgt [N];
    int              m_busy  = 0;
    bit              started = 0;
    logic [VLEN:0]   exp_q [$];
    logic            e_hit;
    logic [VLEN-1:0] e_tgt;
    int              li, wi;

    always @(posedge clk) begin
        started = 1;
        li      = int'(lpc[6:1]);
        e_hit   = 1'b0;
        e_tgt   = '0;
        if (!rst && lv && m_busy == 0 && m_v[li] && (m_pc[li] >> 1) == (lpc >> 1)) begin
            e_hit = 1'b1;
            e_tgt = m_tgt[li];
        end
        exp_q.push_back({e_hit, e_tgt});
        if (rst || flush) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_busy = N;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
        end else if (rb.valid && rb.is_mispredict && rb.cf_type == JumpR && !dbg
                     && rb.target_address[0] == 1'b0) begin
            wi        = int'(rb.pc[6:1]);
            m_v[wi]   = 1'b1;
            m_pc[wi]  = rb.pc;
            m_tgt[wi] = rb.target_address;
        end
    end

    // Monitor: compares busy every cycle and pops one lookup expectation per cycle
    logic [VLEN:0] e;
    always @(negedge clk) begin
        if (started) begin
            n_vec++;
            if (busy !== (m_busy > 0)) begin
                n_miss++;
                $display("FAIL busy t=%0t got=%b want=%b", $time, busy, (m_busy > 0));
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({hit, tgt} !== e) begin
                    n_miss++;
                    $display("FAIL lookup t=%0t got hit=%b tgt=%h want hit=%b tgt=%h",
                             $time, hit, tgt, e[VLEN], e[VLEN-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic set_idle();
        rb    = '0;
        flush = 1'b0;
        dbg   = 1'b0;
        lv    = 1'b0;
        lpc   = '0;
    endtask

    task automatic set_install(input logic [VLEN-1:0] pc, input logic [VLEN-1:0] t,
                               input cf_t cf, input logic misp);
        rb.valid          = 1'b1;
        rb.pc             = pc;
        rb.target_address = t;
        rb.is_mispredict  = misp;
        rb.cf_type        = cf;
    endtask

    task automatic do_lookup(input logic [VLEN-1:0] pc);
        set_idle();
        lv  = 1'b1;
        lpc = pc;
        @(negedge clk);
        set_idle();
    endtask

    // Counts busy cycles from the current negedge; optionally re-pulses flush on one of them
    task automatic count_busy(input int repulse_at, output int n);
        n = 0;
        while (busy && n < 300) begin
            flush = (n == repulse_at);
            n++;
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    function automatic logic [VLEN-1:0] rand_pc();
        logic [VLEN-1:0] p;
        p      = 39'h0_8000_0000;
        p[8:7] = 2'($urandom_range(0, 3));
        p[3:1] = 3'($urandom_range(0, 7));
        p[0]   = 1'($urandom_range(0, 1));
        return p;
    endfunction

    int nb;
    logic [VLEN-1:0] rt;

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Sweep after reset, lookups miss throughout and just after
        lv  = 1'b1;
        lpc = 39'h0_8000_0010;
        count_busy(-1, nb);
        check("reset_busy_len", nb, 64);
        @(negedge clk);
        set_idle();

        // Install then lookup
        set_install(39'h0_8000_0010, 39'h0_8000_2000, JumpR, 1'b1);
        @(negedge clk);
        do_lookup(39'h0_8000_0010);
        @(negedge clk);

        // Alias at idx 8 overwrites
        set_install(39'h0_8000_0090, 39'h0_8000_4000, JumpR, 1'b1);
        @(negedge clk);
        do_lookup(39'h0_8000_0010);
        do_lookup(39'h0_8000_0090);

        // Each filter alone blocks the install
        for (int k = 0; k < 4; k++) begin
            set_idle();
            set_install(39'h0_8000_0020, 39'h0_8000_6000, JumpR, 1'b1);
            if (k == 0) rb.cf_type = Return;
            if (k == 1) rb.is_mispredict = 1'b0;
            if (k == 2) dbg = 1'b1;
            if (k == 3) rb.target_address = 39'h0_8000_2001;
            @(negedge clk);
            do_lookup(39'h0_8000_0020);
        end

        // Flush beats a same-cycle install
        set_install(39'h0_8000_0030, 39'h0_8000_3000, JumpR, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        set_idle();
        count_busy(-1, nb);
        check("flush_busy_len", nb, 64);
        do_lookup(39'h0_8000_0030);

        // Re-pulsed flush extends the sweep and clears prior entries
        set_install(39'h0_8000_0010, 39'h0_8000_2000, JumpR, 1'b1);
        @(negedge clk);
        do_lookup(39'h0_8000_0010);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        count_busy(29, nb);
        check("repulse_busy_len", nb, 94);
        do_lookup(39'h0_8000_0010);
        do_lookup(39'h0_8000_0090);

        // Same-cycle install and lookup returns the old (empty) entry
        set_install(39'h0_8000_0010, 39'h0_8000_2000, JumpR, 1'b1);
        lv  = 1'b1;
        lpc = 39'h0_8000_0010;
        @(negedge clk);
        do_lookup(39'h0_8000_0010);
        @(negedge clk);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            rt      = {7'($urandom), 32'($urandom)};
            rt[0]   = ($urandom_range(0, 9) == 0);
            rb.valid          = ($urandom_range(0, 99) < 45);
            rb.pc             = rand_pc();
            rb.target_address = rt;
            rb.is_mispredict  = ($urandom_range(0, 9) != 0);
            rb.cf_type        = ($urandom_range(0, 9) < 7) ? JumpR : cf_t'(3'($urandom_range(0, 4)));
            dbg   = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 249) == 0);
            lv    = ($urandom_range(0, 2) != 0);
            lpc   = rand_pc();
            @(negedge clk);
        end

        // Reset mid-sweep with a lookup pending
        set_idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        lv  = 1'b1;
        lpc = 39'h0_8000_0010;
        @(negedge clk);
        rst = 1'b0;
        lv  = 1'b0;
        count_busy(-1, nb);
        check("rst_mid_sweep_busy_len", nb, 64);

        set_idle();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
